// File: rtl/tdm_pkg.sv
// Shared TDM link definitions, used by this demux and by the transmit-side 4:1 mux.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package tdm_pkg;

  localparam int NCH    = 4;  // channels per frame
  localparam int SLOT_W = 2;  // bits needed to index a slot

  typedef logic [SLOT_W-1:0] slot_t;

  // Lock state of the receive side.
  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } tdm_state_e;

  localparam slot_t SLOT0     = slot_t'(0);        // slot carrying the frame marker
  localparam slot_t SLOT_LAST = slot_t'(NCH - 1);  // final slot of a frame

  // Slot position after s; wraps modulo NCH because NCH == 2**SLOT_W.
  function automatic slot_t next_slot(input slot_t s);
    return s + slot_t'(1);
  endfunction

endpackage

// File: rtl/tdm_demux4_if.sv
// Incoming TDM sample stream: one W-bit sample per valid cycle plus a slot-0 marker.
// Latency: n/a (wires only).
// Backpressure: none; the receiver must take every valid sample.
// Ports: din (sample), din_valid (sample present), din_sync (slot-0 marker, qualified by din_valid).
interface tdm_demux4_if #(
  parameter int W = 4
);

  logic [W-1:0] din;
  logic         din_valid;
  logic         din_sync;

  modport master (output din, output din_valid, output din_sync);
  modport slave  (input  din, input  din_valid, input  din_sync);

endinterface

// File: rtl/tdm_slot_tracker.sv
// Slot position / lock tracker: HUNT-RUN state, slot counter and flywheel miss counter.
// Latency: decode outputs are combinational from the current sample; locked is the state register.
// Backpressure: none; a sample is consumed whenever ena & din_valid.
// Ports: clk, rst_n, ena, din_valid, din_sync in; wr_en, wr_ch, frame_end, resync, locked out.
module tdm_slot_tracker
  import tdm_pkg::*;
#(
  parameter int MISS_MAX = 2  // consecutive frames without sync before lock is dropped (1..15)
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  ena,
  input  logic  din_valid,
  input  logic  din_sync,
  output logic  wr_en,      // this sample is written to channel wr_ch
  output slot_t wr_ch,
  output logic  frame_end,  // this sample completes a frame (slot 3 written)
  output logic  resync,     // sync seen at a nonzero expected slot
  output logic  locked
);

  localparam logic [3:0] MISS_LIM = 4'(MISS_MAX);

  tdm_state_e state_q, state_d;
  slot_t      slot_q, slot_d;
  logic [3:0] miss_q, miss_d;
  logic [3:0] miss_inc;
  logic       accept;

  assign accept   = ena & din_valid;
  assign miss_inc = miss_q + 4'd1;
  assign locked   = (state_q == RUN);

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    miss_d    = miss_q;
    wr_en     = 1'b0;
    wr_ch     = SLOT0;
    frame_end = 1'b0;
    resync    = 1'b0;

    if (accept) begin
      case (state_q)
        HUNT: begin
          // Only a marked sample can start a frame; everything else is dropped.
          if (din_sync) begin
            wr_en   = 1'b1;
            slot_d  = next_slot(SLOT0);
            state_d = RUN;
            miss_d  = 4'd0;
          end
        end
        RUN: begin
          if (slot_q == SLOT0) begin
            // Flywheel: slot 0 is written whether or not the marker is present.
            wr_en  = 1'b1;
            slot_d = next_slot(SLOT0);
            if (din_sync) begin
              miss_d = 4'd0;
            end else if (miss_inc == MISS_LIM) begin
              state_d = HUNT;
              slot_d  = SLOT0;
              miss_d  = 4'd0;
            end else begin
              miss_d = miss_inc;
            end
          end else if (din_sync) begin
            // Marker arrived early: restart the frame here, abandoning the partial one.
            wr_en  = 1'b1;
            resync = 1'b1;
            slot_d = next_slot(SLOT0);
            miss_d = 4'd0;
          end else begin
            wr_en     = 1'b1;
            wr_ch     = slot_q;
            slot_d    = next_slot(slot_q);
            frame_end = (slot_q == SLOT_LAST);
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      slot_q  <= SLOT0;
      miss_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      miss_q  <= miss_d;
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// 4-channel TDM demux: routes each accepted sample to a registered channel output with strobes.
// Latency: ch_data/ch_stb/frame_done/sync_err one cycle after the accepting edge; locked = state.
// Backpressure: none; ena low freezes everything, din_valid gaps hold slot position.
// Ports: clk, rst_n, ena, rx (tdm_demux4_if.slave: din/din_valid/din_sync),
//        ch_data (channel k at [k*W +: W]), ch_stb, frame_done, locked, sync_err.
// Build option TDM_DEMUX_FRAME_LATCH_EN: samples collect in a shadow bank and ch_data
// updates all four channels at once when a frame completes (ch_stb = 4'b1111).
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int W        = 4,
  parameter int MISS_MAX = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  tdm_demux4_if.slave        rx,
  output logic [NCH*W-1:0]   ch_data,
  output logic [NCH-1:0]     ch_stb,
  output logic               frame_done,
  output logic               locked,
  output logic               sync_err
);

  logic  wr_en;
  slot_t wr_ch;
  logic  frame_end;
  logic  resync;

  tdm_slot_tracker #(
    .MISS_MAX (MISS_MAX)
  ) u_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .din_valid (rx.din_valid),
    .din_sync  (rx.din_sync),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .frame_end (frame_end),
    .resync    (resync),
    .locked    (locked)
  );

  logic [NCH*W-1:0] ch_data_q, ch_data_d;
  logic [NCH-1:0]   ch_stb_q, ch_stb_d;
  logic             frame_done_q, frame_done_d;
  logic             sync_err_q, sync_err_d;

`ifdef TDM_DEMUX_FRAME_LATCH_EN
  logic [NCH*W-1:0] shadow_q, shadow_d;

  always_comb begin
    shadow_d     = shadow_q;
    ch_data_d    = ch_data_q;
    ch_stb_d     = '0;
    frame_done_d = frame_end;
    sync_err_d   = resync;
    if (wr_en) begin
      shadow_d[wr_ch*W +: W] = rx.din;
    end
    // Publish the bank including the slot-3 sample arriving this cycle. Aborted
    // frames never reach here; their shadow slots get overwritten by the next frame.
    if (frame_end) begin
      ch_data_d = shadow_d;
      ch_stb_d  = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end
`else
  always_comb begin
    ch_data_d    = ch_data_q;
    ch_stb_d     = '0;
    frame_done_d = frame_end;
    sync_err_d   = resync;
    if (wr_en) begin
      ch_data_d[wr_ch*W +: W] = rx.din;
      ch_stb_d[wr_ch]         = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_data_q    <= '0;
      ch_stb_q     <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      ch_data_q    <= ch_data_d;
      ch_stb_q     <= ch_stb_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign ch_data    = ch_data_q;
  assign ch_stb     = ch_stb_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4 (W=4, MISS_MAX=2).
// Latency: n/a. Backpressure: n/a.
// Table of {inputs, expected outputs}; expectations queue up as stimulus is driven.
module tb_tdm_demux4;

  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [15:0] ch_data;
  logic [3:0]  ch_stb;
  logic        frame_done;
  logic        locked;
  logic        sync_err;

  tdm_demux4_if #(.W(W)) rx_if ();

  tdm_demux4 #(
    .W        (W),
    .MISS_MAX (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .rx         (rx_if),
    .ch_data    (ch_data),
    .ch_stb     (ch_stb),
    .frame_done (frame_done),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ena;
    logic        vld;
    logic        sync;
    logic [3:0]  din;
    logic [15:0] e_dat;
    logic [3:0]  e_stb;
    logic        e_fd;
    logic        e_lk;
    logic        e_se;
  } vec_t;

  typedef struct {
    logic [15:0] dat;
    logic [3:0]  stb;
    logic        fd;
    logic        lk;
    logic        se;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic e, input logic v, input logic s, input logic [3:0] d,
                     input logic [15:0] dat, input logic [3:0] stb,
                     input logic fd, input logic lk, input logic se);
    vec_t t;
    t.ena = e; t.vld = v; t.sync = s; t.din = d;
    t.e_dat = dat; t.e_stb = stb; t.e_fd = fd; t.e_lk = lk; t.e_se = se;
    tbl.push_back(t);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ch_data"},    ch_data,    16'h0);
    check({tag, " ch_stb"},     ch_stb,     16'h0);
    check({tag, " frame_done"}, frame_done, 16'h0);
    check({tag, " locked"},     locked,     16'h0);
    check({tag, " sync_err"},   sync_err,   16'h0);
  endtask

  // Apply every queued vector for one cycle each, comparing one cycle later.
  task automatic run_table(input string tag);
    exp_t e;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      ena             = tbl[i].ena;
      rx_if.din_valid = tbl[i].vld;
      rx_if.din_sync  = tbl[i].sync;
      rx_if.din       = tbl[i].din;
      e.dat = tbl[i].e_dat; e.stb = tbl[i].e_stb;
      e.fd = tbl[i].e_fd; e.lk = tbl[i].e_lk; e.se = tbl[i].e_se;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL %s v%0d scoreboard empty: got 0 entries expected 1", tag, i);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("%s v%0d ch_data", tag, i),    ch_data,    e.dat);
        check($sformatf("%s v%0d ch_stb", tag, i),     ch_stb,     e.stb);
        check($sformatf("%s v%0d frame_done", tag, i), frame_done, e.fd);
        check($sformatf("%s v%0d locked", tag, i),     locked,     e.lk);
        check($sformatf("%s v%0d sync_err", tag, i),   sync_err,   e.se);
      end
    end
    tbl.delete();
    @(negedge clk);
    ena             = 1'b1;
    rx_if.din_valid = 1'b0;
    rx_if.din_sync  = 1'b0;
  endtask

  initial begin
    rst_n           = 1'b0;
    ena             = 1'b0;
    rx_if.din       = '0;
    rx_if.din_valid = 1'b0;
    rx_if.din_sync  = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

`ifdef TDM_DEMUX_FRAME_LATCH_EN
    // Whole frame appears at once after slot 3.
    add(1,1,1,4'h9, 16'h0000, 4'h0, 0, 1, 0);
    add(1,1,0,4'h8, 16'h0000, 4'h0, 0, 1, 0);
    add(1,1,0,4'h7, 16'h0000, 4'h0, 0, 1, 0);
    add(1,1,0,4'h6, 16'h6789, 4'hF, 1, 1, 0);
    // Aborted frame (resync at slot 2) never reaches ch_data.
    add(1,1,1,4'h1, 16'h6789, 4'h0, 0, 1, 0);
    add(1,1,0,4'h2, 16'h6789, 4'h0, 0, 1, 0);
    add(1,1,1,4'h3, 16'h6789, 4'h0, 0, 1, 1);
    add(1,1,0,4'h4, 16'h6789, 4'h0, 0, 1, 0);
    add(1,1,0,4'h5, 16'h6789, 4'h0, 0, 1, 0);
    add(1,1,0,4'h6, 16'h6543, 4'hF, 1, 1, 0);
    run_table("latch");
`else
    // HUNT: unmarked samples are discarded.
    add(1,1,0,4'h5, 16'h0000, 4'h0, 0, 0, 0);
    add(1,1,0,4'h6, 16'h0000, 4'h0, 0, 0, 0);
    // First frame, sync on slot 0.
    add(1,1,1,4'h1, 16'h0001, 4'h1, 0, 1, 0);
    add(1,1,0,4'h2, 16'h0021, 4'h2, 0, 1, 0);
    add(1,1,0,4'h3, 16'h0321, 4'h4, 0, 1, 0);
    add(1,1,0,4'h4, 16'h4321, 4'h8, 1, 1, 0);
    // Gap holds position.
    add(1,0,0,4'h9, 16'h4321, 4'h0, 0, 1, 0);
    // Early sync at expected slot 2.
    add(1,1,1,4'h5, 16'h4325, 4'h1, 0, 1, 0);
    add(1,1,0,4'h6, 16'h4365, 4'h2, 0, 1, 0);
    add(1,1,1,4'hA, 16'h436A, 4'h1, 0, 1, 1);
    add(1,1,0,4'hB, 16'h43BA, 4'h2, 0, 1, 0);
    add(1,1,0,4'hC, 16'h4CBA, 4'h4, 0, 1, 0);
    add(1,1,0,4'hD, 16'hDCBA, 4'h8, 1, 1, 0);
    // Flywheel: first unmarked frame fully written.
    add(1,1,0,4'h1, 16'hDCB1, 4'h1, 0, 1, 0);
    add(1,1,0,4'h2, 16'hDC21, 4'h2, 0, 1, 0);
    add(1,1,0,4'h3, 16'hD321, 4'h4, 0, 1, 0);
    add(1,1,0,4'h4, 16'h4321, 4'h8, 1, 1, 0);
    // Second miss at slot 0: written, lock drops, the rest is ignored.
    add(1,1,0,4'h5, 16'h4325, 4'h1, 0, 0, 0);
    add(1,1,0,4'h6, 16'h4325, 4'h0, 0, 0, 0);
    add(1,1,0,4'h7, 16'h4325, 4'h0, 0, 0, 0);
    // Relock, reach slot 2, then freeze with ena low.
    add(1,1,1,4'h8, 16'h4328, 4'h1, 0, 1, 0);
    add(1,1,0,4'h9, 16'h4398, 4'h2, 0, 1, 0);
    add(0,1,0,4'hF, 16'h4398, 4'h0, 0, 1, 0);
    add(0,1,1,4'hF, 16'h4398, 4'h0, 0, 1, 0);
    add(0,1,0,4'hF, 16'h4398, 4'h0, 0, 1, 0);
    // Slot 2 was held across the freeze.
    add(1,1,0,4'h7, 16'h4798, 4'h4, 0, 1, 0);
    run_table("main");

    // Mid-frame reset clears everything immediately.
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;

    // First frame after reset needs a sync.
    add(1,1,0,4'h3, 16'h0000, 4'h0, 0, 0, 0);
    add(1,1,1,4'h3, 16'h0003, 4'h1, 0, 1, 0);
    add(1,1,1,4'h4, 16'h0003, 4'h0, 0, 1, 0);  // bubble row replaced below
    tbl.delete(2);
    add(1,1,0,4'h4, 16'h0043, 4'h2, 0, 1, 0);
    add(1,1,1,4'h5, 16'h0045, 4'h1, 0, 1, 1);  // sync at expected slot 2
    run_table("post");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive end of the team's 4-channel time-division link; the 4:1 channel mux is the transmit end.
- Accepts one W-bit sample per valid cycle, plus a frame-sync marker on slot 0.
- Tracks slot position and routes each sample to one of four registered channel outputs, with per-channel update strobes.
- Includes a lock/flywheel state machine for lost or misplaced sync.

Parameters:
- W, 4: sample width in bits; equals the width of each mux channel input.
- MISS_MAX, 2: consecutive frames without sync at slot 0 before lock is dropped; range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  block enable; low freezes all state and ignores inputs
- din  input  W  incoming TDM sample
- din_valid  input  1  din carries a sample this cycle
- din_sync  input  1  frame marker; qualified by din_valid; marks slot 0
- ch_data  output  4*W  channel registers; channel k occupies bits [k*W +: W]
- ch_stb  output  4  one-cycle pulse per channel whose register was written
- frame_done  output  1  one-cycle pulse after the slot-3 sample is accepted
- locked  output  1  high while in the RUN state
- sync_err  output  1  one-cycle pulse on a sync at a nonzero expected slot

Behaviour:
- Reset (asynchronous, rst_n low):
  - ch_data=0, ch_stb=0, frame_done=0, locked=0, sync_err=0.
  - State=HUNT, slot=0, miss counter=0.
- Accept condition: ena & din_valid. With ena low:
  - No state change.
  - Pulse outputs are 0 on the next cycle.
  - ch_data holds.
- HUNT state:
  - Accepted sample without sync is discarded.
  - Accepted sample with din_sync is written as slot 0: ch_data[0] updates, ch_stb[0] pulses, slot becomes 1, state goes to RUN, miss counter clears.
- RUN state, accepted sample:
  - Written to channel=slot; slot increments modulo 4.
  - When slot=3 is written, frame_done pulses in the same cycle as ch_stb[3].
- Sync at expected slot 0: normal operation; miss counter clears.
- Sync at expected slot 1..3:
  - sync_err pulses.
  - Sample is written as slot 0 and slot becomes 1 (resync).
  - The partial frame gets no frame_done.
- No sync at expected slot 0 (flywheel):
  - Sample is still written as slot 0.
  - Miss counter increments.
  - When the counter reaches MISS_MAX, locked drops on the next cycle, state goes to HUNT, and that sample is still written.
- Latency: ch_data, ch_stb, frame_done and sync_err are registered, one cycle after the accepting edge. locked follows the state register.
- Back-to-back valid samples are supported every cycle. Gaps (din_valid low) hold slot position indefinitely.
- Pulse outputs are exactly one cycle wide and default to 0 on every non-accepting cycle.
- Reset asserted mid-frame clears everything immediately. The first frame after release requires a sync.

Optional Feature:
- TDM_DEMUX_FRAME_LATCH_EN defined:
  - Samples are written to an internal shadow bank.
  - ch_data updates all four channels atomically, one cycle after the slot-3 sample is accepted.
  - ch_stb pulses 4'b1111 together with frame_done.
  - A frame aborted by resync or lock loss never reaches ch_data.
- Not defined: per-slot update and per-channel ch_stb as described above; no shadow bank.

Decomposition:
- Shared package tdm_pkg holds:
  - NCH=4 and SLOT_W=2.
  - The state typedef {HUNT, RUN}.
  - A helper constant for the slot-0 index.
- These are shared with the transmit-side mux.
- One natural sub-module: tdm_slot_tracker. It owns the state, slot counter and miss counter, and emits write-enable, channel index, frame_done and sync_err. The top holds the channel (and shadow) registers.

Test Plan:
- Reset, then din=1,2,3,4 valid on consecutive cycles, sync on the first:
  - ch_data=16'h4321, ch_stb pulses 1,2,4,8, frame_done once, locked=1.
- Valid samples 5,6 with no sync while in HUNT:
  - ch_data stays 0, ch_stb=0, locked=0.
- Locked, then din=A with sync at expected slot 2:
  - sync_err pulses, ch_data[0]=A, next sample lands in channel 1, no frame_done for the aborted frame.
- Locked, MISS_MAX=2, two full frames with no sync:
  - Both frames still written.
  - locked drops one cycle after the second missed slot-0 sample.
  - Further samples are ignored.
- Mid-frame (slot 2), toggle ena low for 3 cycles with din_valid high, then rst_n low for 1 cycle:
  - ena low: no writes.
  - rst_n low: all outputs 0 immediately, state HUNT.
- With TDM_DEMUX_FRAME_LATCH_EN, frame 9,8,7,6:
  - ch_data unchanged until one cycle after the slot-3 sample, then 16'h6789 with ch_stb=4'hF.
